regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 14 +
 rtl/reg_scoreboard.sv | 60 ++++++
 rtl/regfile.sv | 80 ++++++++
 tb/tb_regfile.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its
// pending-write scoreboard.
package regfile_pkg;

  localparam int XLEN            = 32;
  localparam int REG_NUM_DEFAULT = 32;
  localparam int REG_AW_DEFAULT  = 5;
  localparam int REG_ZERO        = 0;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t ZERO_WORD = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write tracker: one bit per register marks an in-flight writer,
// and the stall decode flags any source that is pending and not bypassable.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEFAULT,
  parameter int REG_AW  = REG_AW_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  input  logic              flush_in,
  input  logic              re1,
  input  logic [REG_AW-1:0] raddr1,
  input  logic              re2,
  input  logic [REG_AW-1:0] raddr2,
  output logic              stall
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

  logic [REG_NUM-1:0] pending;
  logic [REG_NUM-1:0] pending_nxt;
  logic               blocked1;
  logic               blocked2;

  // Clear first, then set, so a same-index set wins; a flush drops both.
  always_comb begin
    // NOTE: default every always_comb output first so no path infers a latch.
    pending_nxt = pending;
    if (flush_in) begin
      pending_nxt = '0;
    end else begin
      if (clr_en) pending_nxt[clr_addr] = 1'b0;
      if (set_en && (set_addr != ZERO_IDX)) pending_nxt[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst_in) begin
      pending <= '0;
    end else if (rdy_in) begin
      pending <= pending_nxt;
    end
  end

  // A pending source is fine when the write-back in this cycle supplies it.
  assign blocked1 = re1 && (raddr1 != ZERO_IDX) && pending[raddr1]
                    && !(clr_en && (clr_addr == raddr1));
  assign blocked2 = re2 && (raddr2 != ZERO_IDX) && pending[raddr2]
                    && !(clr_en && (clr_addr == raddr2));

  assign stall = !rst_in && (blocked1 || blocked2);

endmodule

// File: rtl/regfile.sv
// Integer register file: two combinational read ports with write-back
// bypass, one write port, and a pending-write scoreboard for ID stalls.
module regfile
  import regfile_pkg::*;
#(
  parameter int REG_NUM = REG_NUM_DEFAULT,
  parameter int REG_AW  = REG_AW_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_w_addr,
  input  word_t             wb_w_data,
  input  logic              id_re1,
  input  logic [REG_AW-1:0] id_raddr1,
  output word_t             id_rdata1,
  input  logic              id_re2,
  input  logic [REG_AW-1:0] id_raddr2,
  output word_t             id_rdata2,
  input  logic              id_set_en,
  input  logic [REG_AW-1:0] id_set_addr,
  input  logic              flush_in,
  output logic              id_stall
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

  word_t             regs [REG_NUM];
  logic [REG_AW-1:0] w_idx;
  logic              unused_addr_hi;

  assign w_idx          = wb_w_addr[REG_AW-1:0];
  assign unused_addr_hi = ^wb_w_addr[XLEN-1:REG_AW];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: the array is reset on purpose: the ISA requires all registers
      // to read zero after reset, so this cannot map onto a RAM macro.
      for (int i = 0; i < REG_NUM; i++) regs[i] <= ZERO_WORD;
    end else if (rdy_in && wb_we && (w_idx != ZERO_IDX)) begin
      regs[w_idx] <= wb_w_data;
    end
  end

  // Register 0 and disabled ports read zero; a same-cycle write-back bypasses.
  always_comb begin
    id_rdata1 = ZERO_WORD;
    if (!rst_in && id_re1 && (id_raddr1 != ZERO_IDX)) begin
      id_rdata1 = (wb_we && (w_idx == id_raddr1)) ? wb_w_data : regs[id_raddr1];
    end
  end

  always_comb begin
    id_rdata2 = ZERO_WORD;
    if (!rst_in && id_re2 && (id_raddr2 != ZERO_IDX)) begin
      id_rdata2 = (wb_we && (w_idx == id_raddr2)) ? wb_w_data : regs[id_raddr2];
    end
  end

  reg_scoreboard #(
    .REG_NUM (REG_NUM),
    .REG_AW  (REG_AW)
  ) u_scoreboard (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .set_en   (id_set_en),
    .set_addr (id_set_addr),
    .clr_en   (wb_we),
    .clr_addr (w_idx),
    .flush_in (flush_in),
    .re1      (id_re1),
    .raddr1   (id_raddr1),
    .re2      (id_re2),
    .raddr2   (id_raddr2),
    .stall    (id_stall)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus random traffic,
// compared against a behavioural model through an expectation queue.
module tb_regfile;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        wb_we;
  logic [31:0] wb_w_addr;
  logic [31:0] wb_w_data;
  logic        id_re1;
  logic [4:0]  id_raddr1;
  logic [31:0] id_rdata1;
  logic        id_re2;
  logic [4:0]  id_raddr2;
  logic [31:0] id_rdata2;
  logic        id_set_en;
  logic [4:0]  id_set_addr;
  logic        flush_in;
  logic        id_stall;

  always #5 clk_in = ~clk_in;

  regfile #(
    .REG_NUM (32),
    .REG_AW  (5)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .wb_we       (wb_we),
    .wb_w_addr   (wb_w_addr),
    .wb_w_data   (wb_w_data),
    .id_re1      (id_re1),
    .id_raddr1   (id_raddr1),
    .id_rdata1   (id_rdata1),
    .id_re2      (id_re2),
    .id_raddr2   (id_raddr2),
    .id_rdata2   (id_rdata2),
    .id_set_en   (id_set_en),
    .id_set_addr (id_set_addr),
    .flush_in    (flush_in),
    .id_stall    (id_stall)
  );

  typedef struct {
    int          idx;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        stall;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          failed    = 0;
  int          step_no   = 0;

  // Architectural model: the register contents and which ones await a write.
  logic [31:0] m_regs [32];
  bit          m_pend [32];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_read(input bit rst, input bit we,
                                           input logic [4:0] wa, input logic [31:0] wd,
                                           input bit re, input logic [4:0] a);
    if (rst || !re || a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit mdl_blocked(input bit we, input logic [4:0] wa,
                                     input bit re, input logic [4:0] a);
    return re && a != 0 && m_pend[a] && !(we && wa == a);
  endfunction

  task automatic step(input bit rst, input bit rdy, input bit we,
                      input logic [31:0] waddr, input logic [31:0] wdata,
                      input bit re1, input logic [4:0] a1,
                      input bit re2, input logic [4:0] a2,
                      input bit set_en, input logic [4:0] sa, input bit flush);
    exp_t       e;
    logic [4:0] wa;
    @(posedge clk_in);
    #1;
    rst_in = rst; rdy_in = rdy; wb_we = we; wb_w_addr = waddr; wb_w_data = wdata;
    id_re1 = re1; id_raddr1 = a1; id_re2 = re2; id_raddr2 = a2;
    id_set_en = set_en; id_set_addr = sa; flush_in = flush;
    wa = waddr[4:0];
    e.idx   = step_no;
    e.d1    = mdl_read(rst, we, wa, wdata, re1, a1);
    e.d2    = mdl_read(rst, we, wa, wdata, re2, a2);
    e.stall = !rst && (mdl_blocked(we, wa, re1, a1) || mdl_blocked(we, wa, re2, a2));
    exp_q.push_back(e);
    step_no++;
    // Advance the model to the state after the coming clock edge.
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_pend[i] = 1'b0;
      end
    end else if (rdy) begin
      if (we && wa != 0) m_regs[wa] = wdata;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else begin
        if (we) m_pend[wa] = 1'b0;
        if (set_en && sa != 0) m_pend[sa] = 1'b1;
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rdata1", e.idx, id_rdata1, e.d1);
      check("rdata2", e.idx, id_rdata2, e.d2);
      check("stall", e.idx, {31'h0, id_stall}, {31'h0, e.stall});
    end
  end

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) != 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    rst_in = 1'b1; rdy_in = 1'b1; wb_we = 1'b0; wb_w_addr = '0; wb_w_data = '0;
    id_re1 = 1'b0; id_raddr1 = '0; id_re2 = 1'b0; id_raddr2 = '0;
    id_set_en = 1'b0; id_set_addr = '0; flush_in = 1'b0;

    // Reset: outputs forced low while reset is held.
    step(1, 1, 0, 0, 0, 1, 5, 1, 7, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 5, 1, 7, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 5, 1, 7, 0, 0, 0);
    // Write then read.
    step(0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
    // Same-cycle bypass.
    step(0, 1, 1, 7, 32'h12345678, 0, 0, 1, 7, 0, 0, 0);
    // Register 0: writes ignored, never pending.
    step(0, 1, 1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    // Pending, stall, write-back release.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    step(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    step(0, 1, 1, 3, 32'hA5A5A5A5, 1, 3, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    // Set beats clear on the same index, then flush.
    step(0, 1, 1, 9, 32'h1, 0, 0, 0, 0, 1, 9, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    // Flush drops a simultaneous set but keeps the write.
    step(0, 1, 1, 10, 32'hBB, 0, 0, 0, 0, 1, 11, 1);
    step(0, 1, 0, 0, 0, 1, 10, 1, 11, 0, 0, 0);
    // rdy_in low freezes state; bypass still visible.
    step(0, 0, 1, 13, 32'hCC, 1, 13, 0, 0, 1, 12, 0);
    step(0, 1, 0, 0, 0, 1, 13, 1, 12, 0, 0, 0);
    // Upper write-address bits ignored.
    step(0, 1, 1, 32'hFFFFFFE2, 32'h22, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    // Reset mid-operation discards writes and pending marks.
    step(0, 1, 1, 6, 32'h55, 0, 0, 0, 0, 1, 4, 0);
    step(1, 0, 1, 6, 32'h77, 1, 6, 1, 4, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 6, 1, 4, 0, 0, 0);

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 1) == 1, {27'($urandom()), rand_addr()}, $urandom(),
           $urandom_range(0, 3) != 0, rand_addr(),
           $urandom_range(0, 3) != 0, rand_addr(),
           $urandom_range(0, 1) == 1, rand_addr(),
           $urandom_range(0, 15) == 0);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_in);
    #1;
    check("drain", -1, 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
